// File: rtl/lsu_master_if.sv
// Command/response handshake plus byte-wide lsu bus for lsu_master.
// The master modport is the sequencer view; slave is the core + lsu side.
interface lsu_master_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic            cmd_wide;
    logic [AW-1:0]   cmd_addr;
    logic [2*DW-1:0] cmd_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [2*DW-1:0] resp_rdata;
    logic            resp_err;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic            re;
    logic            we;
    logic            sp_en;
    logic            sp_we;
    logic            sp_d;
    logic [AW-1:0]   sp_q;
    logic [DW-1:0]   q;

    modport master (
        input  cmd_valid, cmd_op, cmd_wide, cmd_addr, cmd_wdata, resp_ready, sp_q, q,
        output cmd_ready, resp_valid, resp_rdata, resp_err, a, d, re, we, sp_en, sp_we, sp_d
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_wide, cmd_addr, cmd_wdata, resp_ready, sp_q, q,
        input  cmd_ready, resp_valid, resp_rdata, resp_err, a, d, re, we, sp_en, sp_we, sp_d
    );
endinterface

// File: rtl/lsu_master.sv
// Splits 8/16-bit LOAD/STORE/PUSH/POP commands into byte transactions on the lsu.
// Define LSU_MASTER_ALIGN_CHK_EN to reject odd-aligned wide accesses with resp_err.
module lsu_master #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 8
) (
    input logic         clk,
    input logic         rst,
    lsu_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, SPUP, XFER, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_PUSH, OP_POP} op_t;

    localparam logic [1:0] WLAST = 2'(RD_LAT - 1);

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic            wide_q, wide_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2*DW-1:0] wdata_q, wdata_d;
    logic [2*DW-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            n_q, n_d;
    logic [1:0]      wcnt_q, wcnt_d;

    logic            last;
    logic            is_stack;
    logic            is_read;
    logic            wbyte_hi;
    logic            misalign;

`ifdef LSU_MASTER_ALIGN_CHK_EN
    assign misalign = bus.cmd_wide & (bus.cmd_op[1] ? bus.sp_q[0] : bus.cmd_addr[0]);
`else
    assign misalign = 1'b0;
`endif

    assign last     = (n_q == wide_q);
    assign is_stack = op_q[1];
    assign is_read  = (op_q == OP_LOAD) || (op_q == OP_POP);
    // PUSH sends the high byte first so the low byte lands at the lower address
    assign wbyte_hi = (op_q == OP_PUSH) ? (wide_q & ~n_q) : n_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            wide_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            n_q     <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wide_q  <= wide_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            n_q     <= n_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        wide_d         = wide_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        n_d            = n_q;
        wcnt_d         = wcnt_q;
        bus.cmd_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.re         = 1'b0;
        bus.we         = 1'b0;
        bus.sp_we      = 1'b0;
        bus.sp_d       = 1'b0;
        bus.a          = '0;
        bus.d          = '0;

        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    op_d    = op_t'(bus.cmd_op);
                    wide_d  = bus.cmd_wide;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    rdata_d = '0;
                    err_d   = misalign;
                    n_d     = 1'b0;
                    wcnt_d  = '0;
                    if (misalign)
                        state_d = RESP;
                    else if (op_t'(bus.cmd_op) == OP_POP)
                        state_d = SPUP;
                    else
                        state_d = XFER;
                end
            end
            XFER: begin
                bus.a = is_stack ? bus.sp_q : addr_q + {{(AW-1){1'b0}}, n_q};
                if (is_read) begin
                    bus.re  = 1'b1;
                    wcnt_d  = '0;
                    state_d = WAIT;
                end else begin
                    bus.we = 1'b1;
                    bus.d  = wbyte_hi ? wdata_q[2*DW-1:DW] : wdata_q[DW-1:0];
                    if (op_q == OP_PUSH) begin
                        state_d = SPUP;
                    end else if (last) begin
                        state_d = RESP;
                    end else begin
                        n_d     = 1'b1;
                        state_d = XFER;
                    end
                end
            end
            WAIT: begin
                if (wcnt_q == WLAST) begin
                    if (n_q)
                        rdata_d[2*DW-1:DW] = bus.q;
                    else
                        rdata_d[DW-1:0] = bus.q;
                    if (last) begin
                        state_d = RESP;
                    end else begin
                        n_d     = 1'b1;
                        state_d = (op_q == OP_POP) ? SPUP : XFER;
                    end
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            SPUP: begin
                bus.sp_we = 1'b1;
                bus.sp_d  = (op_q == OP_POP);
                if (op_q == OP_POP) begin
                    state_d = XFER;
                end else if (last) begin
                    state_d = RESP;
                end else begin
                    n_d     = 1'b1;
                    state_d = XFER;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sp_en      = is_stack & (state_q != IDLE) & ~err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master: RD_LAT=1 instance with memory/SP model, RD_LAT=3 instance for latency.
`timescale 1ns/1ps
module tb_lsu_master;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam logic [1:0] LOAD = 2'd0, STORE = 2'd1, PUSH = 2'd2, POP = 2'd3;
    localparam logic [1:0] K_RE = 2'd0, K_WE = 2'd1, K_SP = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_master_if #(.AW(AW), .DW(DW)) b1 ();
    lsu_master_if #(.AW(AW), .DW(DW)) b2 ();

    lsu_master #(.RD_LAT(1), .AW(AW), .DW(DW)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    lsu_master #(.RD_LAT(3), .AW(AW), .DW(DW)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    // lsu model for dut1: byte memory, stack pointer, one-cycle read
    logic [7:0]  mem [0:65535];
    logic [15:0] sp;
    logic        sp_set = 1'b0;
    logic [15:0] sp_set_val = 16'h0000;
    logic [7:0]  q1;
    assign b1.sp_q = sp;
    assign b1.q    = q1;
    always @(posedge clk) begin
        if (b1.we) mem[b1.a] <= b1.d;
        if (sp_set) sp <= sp_set_val;
        else if (b1.sp_we) sp <= b1.sp_d ? sp + 16'd1 : sp - 16'd1;
        q1 <= b1.re ? mem[b1.a] : 8'h00;
    end

    // three-cycle read pipe for dut2; data is a function of address, zero otherwise
    logic [7:0] p0 = 8'h00, p1 = 8'h00, p2 = 8'h00;
    assign b2.q    = p2;
    assign b2.sp_q = 16'h0000;
    always @(posedge clk) begin
        p0 <= b2.re ? (b2.a[7:0] ^ 8'h3C) : 8'h00;
        p1 <= p0;
        p2 <= p1;
    end

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [7:0]  d;
        logic        en;
    } ev_t;

    ev_t         log1[$];
    int unsigned re2_cnt  = 0;
    int unsigned bus_err  = 0;
    int unsigned n_chk    = 0;
    int unsigned n_fail   = 0;

    always @(negedge clk) begin
        ev_t e;
        if ({1'b0, b1.re} + {1'b0, b1.we} + {1'b0, b1.sp_we} > 2'd1) bus_err++;
        if ({1'b0, b2.re} + {1'b0, b2.we} + {1'b0, b2.sp_we} > 2'd1) bus_err++;
        if (!b1.re && !b1.we && (b1.a != 16'h0 || b1.d != 8'h0)) bus_err++;
        if (b1.re)    begin e = '{K_RE, b1.a, 8'h00, b1.sp_en}; log1.push_back(e); end
        if (b1.we)    begin e = '{K_WE, b1.a, b1.d, b1.sp_en};  log1.push_back(e); end
        if (b1.sp_we) begin e = '{K_SP, {15'h0, b1.sp_d}, 8'h00, b1.sp_en}; log1.push_back(e); end
        if (b2.re) re2_cnt++;
    end

    function automatic ev_t mk(input logic [1:0] k, input logic [15:0] a, input logic [7:0] d, input logic en);
        mk = '{k, a, d, en};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic set_sp(input logic [15:0] v);
        @(negedge clk);
        sp_set = 1'b1;
        sp_set_val = v;
        @(negedge clk);
        sp_set = 1'b0;
    endtask

    // returns one time unit after the accepting edge (first cycle after accept)
    task automatic issue1(input logic [1:0] op, input logic wide, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic ok);
        ok = 1'b0;
        @(negedge clk);
        b1.cmd_valid = 1'b1;
        b1.cmd_op    = op;
        b1.cmd_wide  = wide;
        b1.cmd_addr  = addr;
        b1.cmd_wdata = wdata;
        for (int i = 0; i < 20; i++) begin
            if (b1.cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            b1.cmd_valid = 1'b0;
            timeout("accept");
            return;
        end
        @(posedge clk);
        #1 b1.cmd_valid = 1'b0;
    endtask

    task automatic wait_resp1(output int lat, output logic ok);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (b1.resp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("resp_valid");
    endtask

    task automatic ack1;
        b1.resp_ready = 1'b1;
        @(posedge clk);
        #1 b1.resp_ready = 1'b0;
    endtask

    task automatic run1(input logic [1:0] op, input logic wide, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata, output logic err,
                        output int lat, output int nstb);
        int unsigned base;
        logic ok;
        base  = log1.size();
        rdata = 16'hxxxx;
        err   = 1'bx;
        lat   = -1;
        issue1(op, wide, addr, wdata, ok);
        if (ok) wait_resp1(lat, ok);
        if (ok) begin
            rdata = b1.resp_rdata;
            err   = b1.resp_err;
            ack1();
        end
        nstb = int'(log1.size() - base);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        wide;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic [15:0] exp_sp;
        int          nstb;
        int          lat;
    } vec_t;

    vec_t        vt [10];
    int unsigned vbase [10];

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat, ns;
        logic        ok;
        int unsigned base;

        vt[0] = '{STORE, 1'b1, 16'h0000, 16'h3064, 16'h0000, 16'h0200, 2, 3};
        vt[1] = '{LOAD,  1'b1, 16'h0000, 16'h0000, 16'h3064, 16'h0200, 2, 5};
        vt[2] = '{LOAD,  1'b0, 16'h0001, 16'h0000, 16'h0030, 16'h0200, 1, 3};
        vt[3] = '{STORE, 1'b0, 16'hFFFF, 16'h0011, 16'h0000, 16'h0200, 1, 2};
        vt[4] = '{STORE, 1'b1, 16'h1234, 16'hC0DE, 16'h0000, 16'h0200, 2, 3};
        vt[5] = '{LOAD,  1'b1, 16'h1234, 16'h0000, 16'hC0DE, 16'h0200, 2, 5};
        vt[6] = '{LOAD,  1'b0, 16'h1235, 16'h0000, 16'h00C0, 16'h0200, 1, 3};
        vt[7] = '{PUSH,  1'b0, 16'h0000, 16'h5577, 16'h0000, 16'h01FF, 2, 3};
        vt[8] = '{POP,   1'b0, 16'h0000, 16'h0000, 16'h0077, 16'h0200, 2, 4};
        vt[9] = '{LOAD,  1'b0, 16'h0200, 16'h0000, 16'h0077, 16'h0200, 1, 3};

        b1.cmd_valid = 1'b0; b1.cmd_op = 2'd0; b1.cmd_wide = 1'b0;
        b1.cmd_addr = 16'h0; b1.cmd_wdata = 16'h0; b1.resp_ready = 1'b0;
        b2.cmd_valid = 1'b0; b2.cmd_op = 2'd0; b2.cmd_wide = 1'b0;
        b2.cmd_addr = 16'h0; b2.cmd_wdata = 16'h0; b2.resp_ready = 1'b0;

        #1;
        check("rst cmd_ready", b1.cmd_ready, 1);
        check("rst resp_valid", b1.resp_valid, 0);
        check("rst strobes", {b1.re, b1.we, b1.sp_we, b1.sp_en}, 0);
        check("rst rdata/err", {b1.resp_rdata, b1.resp_err}, 0);
        check("rst a/d", {b1.a, b1.d}, 0);
        set_sp(16'h0200);
        @(negedge clk) rst = 1'b1;

        // reset mid-XFER of a STORE: we must drop without waiting for a clock
        issue1(STORE, 1'b0, 16'h0050, 16'h00AB, ok);
        #2 check("xfer we high", b1.we, 1);
        rst = 1'b0;
        #1 check("rst xfer we/a/d", {b1.we, b1.a, b1.d}, 0);
        check("rst xfer cmd_ready", b1.cmd_ready, 1);
        @(negedge clk) rst = 1'b1;

        // reset mid-WAIT of a LOAD
        issue1(LOAD, 1'b0, 16'h0050, 16'h0000, ok);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("rst wait strobes", {b1.re, b1.we, b1.sp_we}, 0);
        check("rst wait cmd_ready", b1.cmd_ready, 1);
        check("rst wait resp_valid", b1.resp_valid, 0);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            vbase[i] = log1.size();
            run1(vt[i].op, vt[i].wide, vt[i].addr, vt[i].wdata, rd, er, lat, ns);
            check($sformatf("vec%0d rdata", i), rd, vt[i].exp_rdata);
            check($sformatf("vec%0d err", i), er, 0);
            check($sformatf("vec%0d sp", i), sp, vt[i].exp_sp);
            check($sformatf("vec%0d strobes", i), ns, vt[i].nstb);
            check($sformatf("vec%0d latency", i), lat, vt[i].lat);
        end
        check("store wide byte0", log1[vbase[0]],     mk(K_WE, 16'h0000, 8'h64, 1'b0));
        check("store wide byte1", log1[vbase[0] + 1], mk(K_WE, 16'h0001, 8'h30, 1'b0));
        check("push1 we",         log1[vbase[7]],     mk(K_WE, 16'h0200, 8'h77, 1'b1));
        check("pop1 sp step",     log1[vbase[8]],     mk(K_SP, 16'h0001, 8'h00, 1'b1));

        // wide LOAD across the top of the address space
        base = log1.size();
        run1(LOAD, 1'b1, 16'hFFFF, 16'h0000, rd, er, lat, ns);
`ifdef LSU_MASTER_ALIGN_CHK_EN
        check("wrap err", er, 1);
        check("wrap rdata", rd, 16'h0000);
        check("wrap strobes", ns, 0);
        check("wrap latency", lat, 1);
`else
        check("wrap err", er, 0);
        check("wrap rdata", rd, 16'h6411);
        check("wrap re0", log1[base],     mk(K_RE, 16'hFFFF, 8'h00, 1'b0));
        check("wrap re1", log1[base + 1], mk(K_RE, 16'h0000, 8'h00, 1'b0));
`endif

        // wide PUSH then POP through the stack pointer
        set_sp(16'h0100);
        base = log1.size();
        run1(PUSH, 1'b1, 16'h0000, 16'hBEEF, rd, er, lat, ns);
        check("push strobes", ns, 4);
        check("push ev0", log1[base],     mk(K_WE, 16'h0100, 8'hBE, 1'b1));
        check("push ev1", log1[base + 1], mk(K_SP, 16'h0000, 8'h00, 1'b1));
        check("push ev2", log1[base + 2], mk(K_WE, 16'h00FF, 8'hEF, 1'b1));
        check("push ev3", log1[base + 3], mk(K_SP, 16'h0000, 8'h00, 1'b1));
        check("push sp", sp, 16'h00FE);
        check("push rdata", rd, 16'h0000);
        check("push latency", lat, 5);
        base = log1.size();
        run1(POP, 1'b1, 16'h0000, 16'h0000, rd, er, lat, ns);
        check("pop rdata", rd, 16'hBEEF);
        check("pop sp", sp, 16'h0100);
        check("pop latency", lat, 7);
        check("pop ev1", log1[base + 1], mk(K_RE, 16'h00FF, 8'h00, 1'b1));
        check("pop ev3", log1[base + 3], mk(K_RE, 16'h0100, 8'h00, 1'b1));
        check("sp_en idle", b1.sp_en, 0);

        // response back-pressure with a competing command presented
        issue1(LOAD, 1'b0, 16'h1234, 16'h0000, ok);
        wait_resp1(lat, ok);
        base = log1.size();
        b1.cmd_valid = 1'b1; b1.cmd_op = STORE; b1.cmd_wide = 1'b0;
        b1.cmd_addr = 16'h1234; b1.cmd_wdata = 16'h00FF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d resp_valid", i), b1.resp_valid, 1);
            check($sformatf("hold%0d rdata", i), b1.resp_rdata, 16'h00DE);
            check($sformatf("hold%0d cmd_ready", i), b1.cmd_ready, 0);
        end
        b1.resp_ready = 1'b1;
        @(posedge clk);
        #1 b1.resp_ready = 1'b0;
        b1.cmd_valid = 1'b0;
        @(negedge clk);
        check("hold no strobes", log1.size() - base, 0);
        run1(LOAD, 1'b0, 16'h1234, 16'h0000, rd, er, lat, ns);
        check("hold store ignored", rd, 16'h00DE);

        // RD_LAT=3 instance: 1-byte LOAD latency
        @(negedge clk);
        b2.cmd_valid = 1'b1; b2.cmd_op = LOAD; b2.cmd_wide = 1'b0; b2.cmd_addr = 16'h0008;
        check("lat3 cmd_ready", b2.cmd_ready, 1);
        @(posedge clk);
        #1 b2.cmd_valid = 1'b0;
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (b2.resp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("lat3 resp_valid");
        check("lat3 latency", lat, 5);
        check("lat3 rdata", b2.resp_rdata, 16'h0034);
        check("lat3 re pulses", re2_cnt, 1);
        b2.resp_ready = 1'b1;
        @(posedge clk);
        #1 b2.resp_ready = 1'b0;
        @(negedge clk);
        check("lat3 back to idle", b2.cmd_ready, 1);

        check("bus exclusivity/idle a,d", bus_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
